alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM state type and op decode helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add/subtract modulo 2^DATA_W, error flag for unknown op codes.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              rst,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic              err
);

    always_comb begin
        res = '0;
        err = 1'b0;
        if (!rst) begin
            case (op)
                OP_ADD:  res = src1 + src2;
                OP_SUB:  res = src1 - src2;
                default: err = 1'b1;
            endcase
        end
        zero = (res == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU: IDLE grants, EXEC computes, RESP holds.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic              rsp_valid,
    output logic              rsp_id,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant_any;
    logic              grant_id;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              alu_err;

    alu_arbiter_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .rst (1'b0),
        .op  (op_q),
        .src1(src1_q),
        .src2(src2_q),
        .res (alu_res),
        .zero(alu_zero),
        .err (alu_err)
    );

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        req0_ready = !rst && (state_q == ST_IDLE) && grant_any && !grant_id;
        req1_ready = !rst && (state_q == ST_IDLE) && grant_any && grant_id;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    op_d         = grant_id ? req1_op   : req0_op;
                    src1_d       = grant_id ? req1_src1 : req0_src1;
                    src2_d       = grant_id ? req1_src2 : req0_src2;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_res_d   = alu_res;
                rsp_zero_d  = alu_zero;
                rsp_err_d   = alu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule
